// File: rtl/add_1bit_serial_sched.sv
// add_1bit_serial_sched: round-robin arbiter that feeds W-bit adds LSB-first through one shared
// external full adder and returns sum/carry on a valid/ready response port.
module add_1bit_serial_sched #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0_valid,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         req1_ready,
   output logic         fa_a,
   output logic         fa_b,
   output logic         fa_cin,
   input  logic         fa_sum,
   input  logic         fa_cout,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_sum,
   output logic         rsp_cout,
   output logic         rsp_id
);
   localparam int IW = (W > 1) ? $clog2(W) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [W-1:0] a_sh, b_sh, sum_sh, sum_nx;
   logic [IW-1:0] idx;
   logic carry, ptr, id, g0, g1;
   generate
      if (W > 1) begin : g_shift
         assign sum_nx = {fa_sum, sum_sh[W-1:1]};
      end else begin : g_single
         assign sum_nx = fa_sum;
      end
   endgenerate
   // ptr holds the last grant; on a tie the other requester wins
   always_comb begin
      g0 = req0_valid & (~req1_valid | ptr);
      g1 = req1_valid & (~req0_valid | ~ptr);
      req0_ready = (state == IDLE) & g0;
      req1_ready = (state == IDLE) & g1;
      fa_a = (state == RUN) & a_sh[0];
      fa_b = (state == RUN) & b_sh[0];
      fa_cin = (state == RUN) & carry;
      rsp_valid = state == DONE;
      rsp_sum = rsp_valid ? sum_sh : '0;
      rsp_cout = rsp_valid & carry;
      rsp_id = id;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         a_sh <= '0;
         b_sh <= '0;
         sum_sh <= '0;
         carry <= 1'b0;
         idx <= '0;
         ptr <= 1'b1;
         id <= 1'b0;
      end else begin
         case (state)
            IDLE: if (g0 | g1) begin
               a_sh <= g1 ? req1_a : req0_a;
               b_sh <= g1 ? req1_b : req0_b;
               carry <= 1'b0;
               idx <= '0;
               id <= g1;
               ptr <= g1;
               state <= RUN;
            end
            RUN: begin
               sum_sh <= sum_nx;
               carry <= fa_cout;
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               idx <= idx + IW'(1);
               if (idx == IW'(W - 1)) state <= DONE;
            end
            DONE: if (rsp_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_add_1bit_serial_sched.sv
// tb_add_1bit_serial_sched: directed stimulus with a queue scoreboard for a W=4 and a W=1 instance,
// each driving a behavioural full adder on its shared-adder port.
module tb_add_1bit_serial_sched;
   logic clk = 0, reset = 1;
   logic req0_valid = 0, req1_valid = 0, rsp_ready = 1;
   logic [3:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, rsp_sum;
   logic req0_ready, req1_ready, fa_a, fa_b, fa_cin, fa_sum, fa_cout, rsp_valid, rsp_cout, rsp_id;
   logic v0_1 = 0;
   logic [0:0] a_1 = 0, b_1 = 0, sum_1;
   logic r0rdy_1, r1rdy_1, faa_1, fab_1, facin_1, fasum_1, facout_1, rv_1, cout_1, id_1;
   logic [5:0] q4[$];
   logic [2:0] q1[$];
   int checks = 0, errors = 0, n;
   int exp1[4] = '{0, 1, 1, 2};
   always #5 clk = ~clk;
   assign fa_sum = fa_a ^ fa_b ^ fa_cin;
   assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
   assign fasum_1 = faa_1 ^ fab_1 ^ facin_1;
   assign facout_1 = (faa_1 & fab_1) | (faa_1 & facin_1) | (fab_1 & facin_1);
   add_1bit_serial_sched #(.W(4)) dut4 (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
      .rsp_id(rsp_id)
   );
   add_1bit_serial_sched #(.W(1)) dut1 (
      .clk(clk), .reset(reset),
      .req0_valid(v0_1), .req0_a(a_1), .req0_b(b_1), .req0_ready(r0rdy_1),
      .req1_valid(1'b0), .req1_a(1'b0), .req1_b(1'b0), .req1_ready(r1rdy_1),
      .fa_a(faa_1), .fa_b(fab_1), .fa_cin(facin_1), .fa_sum(fasum_1), .fa_cout(facout_1),
      .rsp_valid(rv_1), .rsp_ready(rsp_ready), .rsp_sum(sum_1), .rsp_cout(cout_1), .rsp_id(id_1)
   );
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (rsp_valid && rsp_ready) begin
         if (q4.size() == 0) chk("rsp4_unexpected", {rsp_id, rsp_cout, rsp_sum}, -1);
         else chk("rsp4", {rsp_id, rsp_cout, rsp_sum}, q4.pop_front());
      end
      if (rv_1 && rsp_ready) begin
         if (q1.size() == 0) chk("rsp1_unexpected", {id_1, cout_1, sum_1}, -1);
         else chk("rsp1", {id_1, cout_1, sum_1}, q1.pop_front());
      end
   end
   task automatic wait_rsp(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end while (!rsp_valid && cyc < 50);
   endtask
   task automatic wait_rsp1(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end while (!rv_1 && cyc < 50);
   endtask
   task automatic single(input bit r, input logic [3:0] a, input logic [3:0] b, input logic [5:0] exp);
      @(posedge clk); #1;
      if (r) begin req1_valid = 1; req1_a = a; req1_b = b; end
      else begin req0_valid = 1; req0_a = a; req0_b = b; end
      @(negedge clk);
      chk("grant_single", {req1_ready, req0_ready}, r ? 2 : 1);
      q4.push_back(exp);
      @(posedge clk); #1;
      req0_valid = 0;
      req1_valid = 0;
      wait_rsp(n);
      chk("latency4", n, 4);
      @(posedge clk);
   endtask
   task automatic drain();
      int k = 0;
      while ((q4.size() != 0 || q1.size() != 0) && k < 100) begin
         @(posedge clk);
         k++;
      end
      chk("drain_left", q4.size() + q1.size(), 0);
   endtask
   initial begin
      bit seen;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_outs", {req0_ready, req1_ready, fa_a, fa_b, fa_cin, rsp_valid, rsp_cout, rsp_id}, 0);
      chk("rst_sum", rsp_sum, 0);
      chk("rst_w1", {r0rdy_1, rv_1, sum_1, cout_1}, 0);
      @(posedge clk); #1;
      reset = 0;
      // a=5 b=3 on req0, with a look at the first bit driven to the adder
      @(posedge clk); #1;
      req0_valid = 1; req0_a = 5; req0_b = 3;
      @(negedge clk);
      chk("req0_ready", req0_ready, 1);
      chk("req1_ready_idle", req1_ready, 0);
      q4.push_back({1'b0, 1'b0, 4'd8});
      @(posedge clk); #1;
      req0_valid = 0;
      @(negedge clk);
      chk("run_ready", req0_ready, 0);
      chk("fa_bit0", {fa_a, fa_b, fa_cin}, 3'b110);
      @(posedge clk);
      @(negedge clk);
      chk("fa_bit1_cin", {fa_a, fa_b, fa_cin}, 3'b011);
      n = 0;
      while (!rsp_valid && n < 50) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk("latency_first", n + 1, 4);
      @(posedge clk);
      single(1, 15, 1, {1'b1, 1'b1, 4'd0});
      // both held from reset: grants must alternate starting with req0
      @(posedge clk); #1;
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
      req0_valid = 1; req0_a = 6; req0_b = 7;
      req1_valid = 1; req1_a = 9; req1_b = 9;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!(req0_ready | req1_ready) && n < 40);
         chk("alt_grant", {req1_ready, req0_ready}, (k == 1) ? 2 : 1);
         q4.push_back((k == 1) ? {1'b1, 1'b1, 4'd2} : {1'b0, 1'b0, 4'd13});
         @(posedge clk);
      end
      #1;
      req0_valid = 0;
      req1_valid = 0;
      drain();
      // backpressure: result must hold and no new grant while rsp_ready is low
      @(posedge clk); #1;
      rsp_ready = 0;
      req0_valid = 1; req0_a = 10; req0_b = 4;
      @(negedge clk);
      chk("bp_grant", {req1_ready, req0_ready}, 1);
      q4.push_back({1'b0, 1'b0, 4'd14});
      @(posedge clk); #1;
      req0_valid = 0;
      wait_rsp(n);
      chk("bp_latency", n, 4);
      req0_valid = 1;
      req1_valid = 1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("bp_hold", {rsp_valid, rsp_id, rsp_cout, rsp_sum}, {1'b1, 1'b0, 1'b0, 4'd14});
         chk("bp_no_ready", {req1_ready, req0_ready}, 0);
      end
      @(posedge clk); #1;
      req0_valid = 0;
      req1_valid = 0;
      rsp_ready = 1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_released", rsp_valid, 0);
      // abort on the second RUN cycle
      @(posedge clk); #1;
      req1_valid = 1; req1_a = 3; req1_b = 3;
      @(negedge clk);
      chk("abort_grant", {req1_ready, req0_ready}, 2);
      @(posedge clk); #1;
      req1_valid = 0;
      @(posedge clk); #1;
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
      chk("abort_outs", {rsp_valid, fa_a, fa_b, fa_cin, rsp_id, rsp_cout}, 0);
      chk("abort_sum", rsp_sum, 0);
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         seen |= rsp_valid;
      end
      chk("abort_no_rsp", seen, 0);
      @(posedge clk); #1;
      req0_valid = 1; req0_a = 1; req0_b = 2;
      req1_valid = 1; req1_a = 4; req1_b = 4;
      @(negedge clk);
      chk("post_reset_grant", {req1_ready, req0_ready}, 1);
      q4.push_back({1'b0, 1'b0, 4'd3});
      @(posedge clk); #1;
      req0_valid = 0;
      req1_valid = 0;
      drain();
      // W=1 full-adder truth table through req0
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         v0_1 = 1;
         a_1 = 1'(i >> 1);
         b_1 = 1'(i);
         @(negedge clk);
         chk("w1_ready", r0rdy_1, 1);
         q1.push_back({1'b0, 2'(exp1[i])});
         @(posedge clk); #1;
         v0_1 = 0;
         wait_rsp1(n);
         chk("w1_latency", n, 1);
         @(posedge clk);
      end
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
